// File: rtl/op_dispatcher_if.sv
// Request, execution-unit and result signals of the op_dispatcher.
// The dispatcher uses the slave side; the input stage, units and display
// stage together form the master side.
interface op_dispatcher_if #(
  parameter int N = 16
);
  logic                   in_valid;
  logic signed [N-1:0]    in_a;
  logic signed [N-1:0]    in_b;
  logic [3:0]             in_opcode;
  logic                   abort;

  logic [5:0]             unit_start;
  logic [5:0]             unit_abort;
  logic [3:0]             unit_op;
  logic signed [N-1:0]    unit_a;
  logic signed [N-1:0]    unit_b;
  logic [5:0]             unit_done;
  logic [5:0]             unit_err;
  logic [6*2*N-1:0]       unit_res;

  logic                   busy;
  logic                   res_valid;
  logic signed [2*N-1:0]  result;
  logic [2:0]             err_code;
  logic                   overrun;

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, abort,
    input  unit_done, unit_err, unit_res,
    output unit_start, unit_abort, unit_op, unit_a, unit_b,
    output busy, res_valid, result, err_code, overrun
  );

  modport master (
    output in_valid, in_a, in_b, in_opcode, abort,
    output unit_done, unit_err, unit_res,
    input  unit_start, unit_abort, unit_op, unit_a, unit_b,
    input  busy, res_valid, result, err_code, overrun
  );
endinterface

// File: rtl/op_dispatcher.sv
// Request sequencer for the calculator: latches one request, pre-checks the
// operands, starts exactly one execution unit, supervises it with a timeout
// and hands one result plus status code to the display stage.
//
// state  | meaning
// IDLE   | waiting for in_valid; operands/opcode latched on acceptance
// CHECK  | decode opcode, reject illegal operand cases
// ISSUE  | unit_start pulse visible, timeout counter cleared
// WAIT   | waiting for the selected unit's done, counter running
// DONE   | res_valid pulse visible with new result/err_code
//
// Opcode encoding: 0 SUM, 1 SUB, 2 MUL, 3 DIV, 4 SQRT, 5 POW, 6 LOG, 7 EXP,
// 8 SIN, 9 COS, 10 TAN; 11..15 unmapped.
module op_dispatcher #(
  parameter int N       = 16,
  parameter int TIMEOUT = 4096
) (
  input logic         clk,
  input logic         rst_n,
  op_dispatcher_if.slave bus
);

  localparam int RW = 2 * N;
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [3:0] OP_SUM  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SQRT = 4'd4;
  localparam logic [3:0] OP_POW  = 4'd5;
  localparam logic [3:0] OP_LOG  = 4'd6;
  localparam logic [3:0] OP_EXP  = 4'd7;
  localparam logic [3:0] OP_SIN  = 4'd8;
  localparam logic [3:0] OP_COS  = 4'd9;
  localparam logic [3:0] OP_TAN  = 4'd10;

  localparam logic [2:0] EC_OK      = 3'd0;
  localparam logic [2:0] EC_BADOP   = 3'd1;
  localparam logic [2:0] EC_DIV0    = 3'd2;
  localparam logic [2:0] EC_DOMAIN  = 3'd3;
  localparam logic [2:0] EC_TIMEOUT = 3'd4;
  localparam logic [2:0] EC_UNITERR = 3'd5;

  // The abort is issued one cycle early so that it lands on the last WAIT cycle.
  localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    sel;
  logic [5:0]    sel_oh;

  logic [2:0]    dec_sel;
  logic          dec_bad;
  logic          dec_div0;
  logic          dec_dom;

  logic [RW-1:0] res_sel;
  logic          done_sel;
  logic          err_sel;

  // Map the latched opcode to its unit and flag illegal operand combinations.
  always_comb begin
    dec_sel  = 3'd0;
    dec_bad  = 1'b0;
    dec_div0 = 1'b0;
    dec_dom  = 1'b0;
    case (bus.unit_op)
      OP_SUM, OP_SUB: dec_sel = 3'd0;
      OP_MUL:         dec_sel = 3'd1;
      OP_DIV: begin
        dec_sel  = 3'd2;
        dec_div0 = (bus.unit_b == '0);
      end
      OP_SQRT: begin
        dec_sel = 3'd3;
        dec_dom = bus.unit_a[N-1];
      end
      OP_POW, OP_EXP: dec_sel = 3'd4;
      OP_LOG: begin
        dec_sel = 3'd4;
        dec_dom = bus.unit_a[N-1] || (bus.unit_a == '0);
      end
      OP_SIN, OP_COS, OP_TAN: dec_sel = 3'd5;
      default: dec_bad = 1'b1;
    endcase
  end

  // Pick the selected unit's done, error and result slice; other units are ignored.
  always_comb begin
    res_sel  = '0;
    done_sel = 1'b0;
    err_sel  = 1'b0;
    sel_oh   = 6'b000001 << sel;
    for (int k = 0; k < 6; k++) begin
      if (sel == 3'(k)) begin
        res_sel  = bus.unit_res[k*RW +: RW];
        done_sel = bus.unit_done[k];
        err_sel  = bus.unit_err[k];
      end
    end
  end

  // Sequencer with registered outputs; abort overrides every other transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      sel            <= 3'd0;
      bus.unit_start <= '0;
      bus.unit_abort <= '0;
      bus.unit_op    <= '0;
      bus.unit_a     <= '0;
      bus.unit_b     <= '0;
      bus.busy       <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.result     <= '0;
      bus.err_code   <= EC_OK;
      bus.overrun    <= 1'b0;
    end else begin
      bus.unit_start <= '0;
      bus.unit_abort <= '0;
      bus.res_valid  <= 1'b0;
      if (bus.in_valid && state != S_IDLE) begin
        bus.overrun <= 1'b1;
      end
      if (bus.abort) begin
        if (state == S_WAIT) begin
          bus.unit_abort <= sel_oh;
        end
        state    <= S_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.in_valid) begin
              bus.unit_a  <= bus.in_a;
              bus.unit_b  <= bus.in_b;
              bus.unit_op <= bus.in_opcode;
              bus.busy    <= 1'b1;
              state       <= S_CHECK;
            end
          end
          S_CHECK: begin
            sel <= dec_sel;
            if (dec_bad || dec_div0 || dec_dom) begin
              bus.result    <= '0;
              bus.err_code  <= dec_bad ? EC_BADOP : (dec_div0 ? EC_DIV0 : EC_DOMAIN);
              bus.res_valid <= 1'b1;
              state         <= S_DONE;
            end else begin
              bus.unit_start <= 6'b000001 << dec_sel;
              state          <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            cnt   <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (done_sel) begin
              bus.result    <= res_sel;
              bus.err_code  <= err_sel ? EC_UNITERR : EC_OK;
              bus.res_valid <= 1'b1;
              state         <= S_DONE;
            end else if (cnt == CNT_LAST) begin
              bus.result    <= '0;
              bus.err_code  <= EC_TIMEOUT;
              bus.res_valid <= 1'b1;
              state         <= S_DONE;
            end else begin
              if (cnt == CNT_PRE) begin
                bus.unit_abort <= sel_oh;
              end
              cnt <= cnt + 1'b1;
            end
          end
          S_DONE: begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Self-checking bench for op_dispatcher. The bench plays the input stage and
// all six execution units; expected outcomes come from a small opcode/operand
// rule model plus the documented cycle timing.
module tb_op_dispatcher;
  localparam int N  = 16;
  localparam int TO = 8;
  localparam int RW = 2 * N;

  localparam logic [3:0] OP_SUM = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3;
  localparam logic [3:0] OP_SQRT = 4'd4, OP_POW = 4'd5, OP_LOG = 4'd6, OP_EXP = 4'd7;
  localparam logic [3:0] OP_SIN = 4'd8, OP_COS = 4'd9, OP_TAN = 4'd10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  op_dispatcher_if #(.N(N)) bus();
  op_dispatcher #(.N(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_last_res = '0;
  logic [2:0]    exp_last_ec  = 3'd0;

  // Reference rules: which unit an opcode belongs to and which pre-check error applies.
  function automatic void model(input logic [3:0] op, input logic signed [N-1:0] a,
                                input logic signed [N-1:0] b, output int unit, output int pre);
    unit = -1;
    pre  = 0;
    if (op == OP_SUM || op == OP_SUB) unit = 0;
    else if (op == OP_MUL) unit = 1;
    else if (op == OP_DIV) unit = 2;
    else if (op == OP_SQRT) unit = 3;
    else if (op == OP_POW || op == OP_LOG || op == OP_EXP) unit = 4;
    else if (op == OP_SIN || op == OP_COS || op == OP_TAN) unit = 5;
    else pre = 1;
    if (op == OP_DIV && b == 0) pre = 2;
    if (op == OP_SQRT && a < 0) pre = 3;
    if (op == OP_LOG && a <= 0) pre = 3;
    if (pre != 0) unit = -1;
  endfunction

  // Issue one request at cycle 0 and act as the units; report when things happened.
  // dly = cycles from start to done of unit uidx (0 = unit never answers).
  task automatic run_op(input logic [3:0] op, input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                        input int uidx, input int dly, input logic [RW-1:0] ures, input logic uerr,
                        output int t_start, output logic [5:0] start_vec, output int t_rv,
                        output logic [RW-1:0] res, output logic [2:0] ec, output int t_abort,
                        output logic [5:0] abort_vec, output int t_idle);
    t_start = -1; start_vec = '0; t_rv = -1; res = '0; ec = '0;
    t_abort = -1; abort_vec = '0; t_idle = -1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b;
    for (int k = 1; k <= 30 && t_idle < 0; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.unit_start != 0 && t_start < 0) begin t_start = k; start_vec = bus.unit_start; end
      if (bus.unit_abort != 0 && t_abort < 0) begin t_abort = k; abort_vec = bus.unit_abort; end
      if (bus.res_valid && t_rv < 0) begin t_rv = k; res = bus.result; ec = bus.err_code; end
      if (!bus.busy) t_idle = k;
      // Other units chatter randomly; the dispatcher must ignore them.
      bus.unit_done = 6'($urandom);
      bus.unit_err  = 6'($urandom);
      for (int j = 0; j < 6; j++) bus.unit_res[j*RW +: RW] = RW'($urandom);
      if (uidx >= 0) begin
        bus.unit_done[uidx] = 1'b0;
        bus.unit_err[uidx]  = 1'b0;
        if (t_start >= 0 && dly > 0 && k == t_start + dly) begin
          bus.unit_done[uidx] = 1'b1;
          bus.unit_err[uidx]  = uerr;
          bus.unit_res[uidx*RW +: RW] = ures;
        end
      end
    end
    bus.unit_done = '0;
    bus.unit_err  = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d, expected 0", bus.busy); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %0d, expected 0", bus.res_valid); end
    n_vec++; if (bus.result !== '0) begin n_err++; $display("FAIL reset_result: got %0d, expected 0", bus.result); end
    n_vec++; if (bus.err_code !== 3'd0) begin n_err++; $display("FAIL reset_err_code: got %0d, expected 0", bus.err_code); end
    n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0d, expected 0", bus.overrun); end
    n_vec++; if ({bus.unit_start, bus.unit_abort} !== 12'd0) begin n_err++; $display("FAIL reset_unit_pulses: got %b, expected 0", {bus.unit_start, bus.unit_abort}); end
    n_vec++; if ({bus.unit_op, bus.unit_a, bus.unit_b} !== '0) begin n_err++; $display("FAIL reset_unit_regs: got %h, expected 0", {bus.unit_op, bus.unit_a, bus.unit_b}); end
    rst_n = 1'b1;
  endtask

  task automatic test_sum();
    int ts, tr, ta, ti; logic [5:0] sv, av; logic [RW-1:0] r; logic [2:0] e;
    run_op(OP_SUM, 16'sd100, -16'sd25, 0, 2, RW'(75), 1'b0, ts, sv, tr, r, e, ta, av, ti);
    n_vec++; if (ts !== 2) begin n_err++; $display("FAIL sum_start_cycle: got %0d, expected 2", ts); end
    n_vec++; if (sv !== 6'b000001) begin n_err++; $display("FAIL sum_start_vec: got %b, expected 000001", sv); end
    n_vec++; if (tr !== 5) begin n_err++; $display("FAIL sum_res_valid_cycle: got %0d, expected 5", tr); end
    n_vec++; if (r !== RW'(75)) begin n_err++; $display("FAIL sum_result: got %0d, expected 75", r); end
    n_vec++; if (e !== 3'd0) begin n_err++; $display("FAIL sum_err_code: got %0d, expected 0", e); end
    n_vec++; if (ti !== 6) begin n_err++; $display("FAIL sum_idle_cycle: got %0d, expected 6", ti); end
    n_vec++; if (bus.unit_op !== OP_SUM || bus.unit_a !== 16'sd100 || bus.unit_b !== -16'sd25) begin
      n_err++; $display("FAIL sum_unit_hold: got op=%0d a=%0d b=%0d, expected 0/100/-25", bus.unit_op, bus.unit_a, bus.unit_b); end
  endtask

  task automatic test_precheck();
    logic [3:0] ops[4]; logic signed [N-1:0] as[4], bs[4]; logic [2:0] ecs[4];
    int ts, tr, ta, ti; logic [5:0] sv, av; logic [RW-1:0] r; logic [2:0] e;
    ops = '{OP_DIV, OP_LOG, OP_SQRT, 4'd13};
    as  = '{16'sd50, 16'sd0, -16'sd4, 16'sd1};
    bs  = '{16'sd0, 16'sd7, 16'sd0, 16'sd1};
    ecs = '{3'd2, 3'd3, 3'd3, 3'd1};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], -1, 0, '0, 1'b0, ts, sv, tr, r, e, ta, av, ti);
      n_vec++; if (ts !== -1) begin n_err++; $display("FAIL pre%0d_no_start: got start at %0d vec %b, expected none", i, ts, sv); end
      n_vec++; if (tr !== 2) begin n_err++; $display("FAIL pre%0d_res_valid_cycle: got %0d, expected 2", i, tr); end
      n_vec++; if (r !== '0) begin n_err++; $display("FAIL pre%0d_result: got %0d, expected 0", i, r); end
      n_vec++; if (e !== ecs[i]) begin n_err++; $display("FAIL pre%0d_err_code: got %0d, expected %0d", i, e, ecs[i]); end
      n_vec++; if (ti !== 3) begin n_err++; $display("FAIL pre%0d_idle_cycle: got %0d, expected 3", i, ti); end
    end
  endtask

  task automatic test_timeout();
    int ts, tr, ta, ti; logic [5:0] sv, av; logic [RW-1:0] r; logic [2:0] e;
    run_op(OP_MUL, 16'sd3, 16'sd4, 1, 0, '0, 1'b0, ts, sv, tr, r, e, ta, av, ti);
    n_vec++; if (ta !== 2 + TO) begin n_err++; $display("FAIL tmo_abort_cycle: got %0d, expected %0d", ta, 2 + TO); end
    n_vec++; if (av !== 6'b000010) begin n_err++; $display("FAIL tmo_abort_vec: got %b, expected 000010", av); end
    n_vec++; if (tr !== 3 + TO) begin n_err++; $display("FAIL tmo_res_valid_cycle: got %0d, expected %0d", tr, 3 + TO); end
    n_vec++; if (e !== 3'd4 || r !== '0) begin n_err++; $display("FAIL tmo_status: got ec=%0d res=%0d, expected 4/0", e, r); end
  endtask

  task automatic test_done_last_cycle();
    int ts, tr, ta, ti; logic [5:0] sv, av; logic [RW-1:0] r; logic [2:0] e;
    run_op(OP_MUL, 16'sd7, -16'sd6, 1, TO, RW'(-42), 1'b0, ts, sv, tr, r, e, ta, av, ti);
    n_vec++; if (tr !== 3 + TO) begin n_err++; $display("FAIL last_res_valid_cycle: got %0d, expected %0d", tr, 3 + TO); end
    n_vec++; if (r !== RW'(-42) || e !== 3'd0) begin n_err++; $display("FAIL last_done_wins: got res=%0d ec=%0d, expected -42/0", $signed(r), e); end
    exp_last_res = RW'(-42);
    exp_last_ec  = 3'd0;
  endtask

  task automatic test_abort();
    @(negedge clk); bus.in_valid = 1'b1; bus.in_opcode = OP_SIN; bus.in_a = 16'sd5; bus.in_b = 16'sd3;
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.unit_start !== 6'b100000) begin n_err++; $display("FAIL abort_start_vec: got %b, expected 100000", bus.unit_start); end
    @(negedge clk); bus.in_valid = 1'b1; bus.in_opcode = OP_SUM; bus.in_a = 16'sd9; bus.in_b = 16'sd9;
    @(negedge clk); bus.in_valid = 1'b0;
    n_vec++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL abort_overrun: got %0d, expected 1", bus.overrun); end
    bus.abort = 1'b1; bus.unit_done = 6'b100000; bus.unit_res[5*RW +: RW] = RW'(77);
    @(negedge clk); bus.abort = 1'b0; bus.unit_done = '0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: got busy %0d, expected 0", bus.busy); end
    n_vec++; if (bus.unit_abort !== 6'b100000) begin n_err++; $display("FAIL abort_unit_abort: got %b, expected 100000", bus.unit_abort); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_res_valid: got %0d, expected 0", bus.res_valid); end
    n_vec++; if (bus.result !== exp_last_res || bus.err_code !== exp_last_ec) begin
      n_err++; $display("FAIL abort_result_held: got %0d/%0d, expected %0d/%0d", bus.result, bus.err_code, $signed(exp_last_res), exp_last_ec); end
    n_vec++; if (bus.unit_a !== 16'sd5 || bus.unit_op !== OP_SIN) begin
      n_err++; $display("FAIL abort_dropped_req: got op=%0d a=%0d, expected 8/5", bus.unit_op, bus.unit_a); end
    @(negedge clk);
    n_vec++; if (bus.res_valid !== 1'b0 || bus.unit_abort !== '0) begin
      n_err++; $display("FAIL abort_quiet: got res_valid=%0d unit_abort=%b, expected 0/0", bus.res_valid, bus.unit_abort); end
    bus.in_valid = 1'b1; bus.abort = 1'b1; bus.in_opcode = OP_MUL; bus.in_a = 16'sd11;
    @(negedge clk); bus.in_valid = 1'b0; bus.abort = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.unit_a !== 16'sd5) begin
      n_err++; $display("FAIL abort_vs_in_valid: got busy=%0d a=%0d, expected 0/5", bus.busy, bus.unit_a); end
  endtask

  task automatic test_reset_mid_wait();
    int ts, tr, ta, ti; logic [5:0] sv, av; logic [RW-1:0] r; logic [2:0] e;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_opcode = OP_MUL; bus.in_a = 16'sd4; bus.in_b = 16'sd6;
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.busy, bus.res_valid, bus.overrun} !== 3'b000) begin
      n_err++; $display("FAIL rstw_flags: got busy/rv/ovr=%b, expected 000", {bus.busy, bus.res_valid, bus.overrun}); end
    n_vec++; if (bus.result !== '0 || bus.err_code !== 3'd0) begin
      n_err++; $display("FAIL rstw_result: got %0d/%0d, expected 0/0", bus.result, bus.err_code); end
    n_vec++; if ({bus.unit_start, bus.unit_abort} !== 12'd0) begin
      n_err++; $display("FAIL rstw_pulses: got %b, expected 0", {bus.unit_start, bus.unit_abort}); end
    n_vec++; if ({bus.unit_op, bus.unit_a, bus.unit_b} !== '0) begin
      n_err++; $display("FAIL rstw_unit_regs: got %h, expected 0", {bus.unit_op, bus.unit_a, bus.unit_b}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.unit_abort !== '0) begin n_err++; $display("FAIL rstw_no_abort: got %b, expected 0", bus.unit_abort); end
    run_op(OP_POW, 16'sd3, 16'sd2, 4, 3, RW'(9), 1'b1, ts, sv, tr, r, e, ta, av, ti);
    n_vec++; if (sv !== 6'b010000 || tr !== 6) begin n_err++; $display("FAIL pow_timing: got vec=%b rv=%0d, expected 010000/6", sv, tr); end
    n_vec++; if (e !== 3'd5 || r !== RW'(9)) begin n_err++; $display("FAIL pow_uniterr: got ec=%0d res=%0d, expected 5/9", e, r); end
  endtask

  task automatic test_random();
    int ts, tr, ta, ti, unit, pre, dly, x_ts, x_tr, x_ti; logic [5:0] sv, av; logic [RW-1:0] r, ures, x_res;
    logic [2:0] e, x_ec; logic uerr; logic [3:0] op; logic signed [N-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3)) 0: a = '0; 1: a = -N'($urandom_range(1, 50)); default: a = N'($urandom); endcase
      case ($urandom_range(0, 3)) 0: b = '0; 1: b = -N'($urandom_range(1, 50)); default: b = N'($urandom); endcase
      dly  = $urandom_range(0, TO);
      ures = RW'($urandom);
      uerr = 1'($urandom_range(0, 1));
      model(op, a, b, unit, pre);
      run_op(op, a, b, unit, dly, ures, uerr, ts, sv, tr, r, e, ta, av, ti);
      if (pre != 0) begin
        x_ts = -1; x_tr = 2; x_res = '0; x_ec = 3'(pre); x_ti = 3;
      end else if (dly == 0) begin
        x_ts = 2; x_tr = 3 + TO; x_res = '0; x_ec = 3'd4; x_ti = 4 + TO;
      end else begin
        x_ts = 2; x_tr = 3 + dly; x_res = ures; x_ec = uerr ? 3'd5 : 3'd0; x_ti = 4 + dly;
      end
      n_vec++; if (ts !== x_ts || (unit >= 0 && sv !== 6'(1 << unit))) begin
        n_err++; $display("FAIL rnd%0d_start op=%0d: got cycle %0d vec %b, expected cycle %0d unit %0d", i, op, ts, sv, x_ts, unit); end
      n_vec++; if (tr !== x_tr) begin n_err++; $display("FAIL rnd%0d_rv_cycle op=%0d: got %0d, expected %0d", i, op, tr, x_tr); end
      n_vec++; if (r !== x_res || e !== x_ec) begin
        n_err++; $display("FAIL rnd%0d_result op=%0d: got %h/%0d, expected %h/%0d", i, op, r, e, x_res, x_ec); end
      n_vec++; if (ti !== x_ti) begin n_err++; $display("FAIL rnd%0d_idle op=%0d: got %0d, expected %0d", i, op, ti, x_ti); end
      if (pre == 0 && dly == 0) begin
        n_vec++; if (ta !== 2 + TO || av !== 6'(1 << unit)) begin
          n_err++; $display("FAIL rnd%0d_abort: got cycle %0d vec %b, expected %0d unit %0d", i, ta, av, 2 + TO, unit); end
      end else if (dly < TO) begin
        n_vec++; if (ta !== -1) begin n_err++; $display("FAIL rnd%0d_spurious_abort: got cycle %0d vec %b, expected none", i, ta, av); end
      end
      n_vec++; if (bus.unit_op !== op || bus.unit_a !== a || bus.unit_b !== b) begin
        n_err++; $display("FAIL rnd%0d_unit_hold: got %0d/%0d/%0d, expected %0d/%0d/%0d", i, bus.unit_op, bus.unit_a, bus.unit_b, op, a, b); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_opcode = '0; bus.abort = 1'b0;
    bus.unit_done = '0; bus.unit_err = '0; bus.unit_res = '0;
    test_reset();
    test_sum();
    test_precheck();
    test_timeout();
    test_done_last_cycle();
    test_abort();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/op_dispatcher.md
# op_dispatcher

Sequencer between the operand/opcode input stage and the calculator's arithmetic units. Latches one request (a, b, opcode) per input-done pulse and pre-checks operands for illegal cases. Routes the request to exactly one of six execution units through a start/done handshake, supervises it with a timeout, and returns one result with a status code to the display stage.

## Interface
- N, default `INPUTWIDTH: operand width; results are 2N bits.
- TIMEOUT, default 4096: maximum WAIT cycles before a unit is declared hung; must be ≥2.
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- in_valid  in  1  one-cycle request pulse (input stage done).
- in_a, in_b  in  N each  signed operands.
- in_opcode  in  4  opcode, encodings from define.v.
- abort  in  1  cancel current operation.
- unit_start  out  6  one-hot start pulse; bit 0 ALU (SUM/SUB), 1 MUL, 2 DIV, 3 SQRT, 4 TRANS (POW/LOG/EXP), 5 TRIG (SIN/COS/TAN).
- unit_abort  out  6  one-hot abort pulse to the unit being waited on.
- unit_op  out  4  registered opcode, held stable from ISSUE until the next accepted request.
- unit_a, unit_b  out  N each  registered operands, same hold rule as unit_op.
- unit_done  in  6  per-unit completion pulse.
- unit_err  in  6  per-unit error, sampled only together with that unit's done.
- unit_res  in  6·2N  flattened results; unit k occupies bits [k·2N +: 2N].
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle pulse: result and err_code are new.
- result  out  2N  signed result, held until the next res_valid.
- err_code  out  3  0 OK, 1 BADOP, 2 DIV0, 3 DOMAIN, 4 TIMEOUT, 5 UNITERR; held with result.
- overrun  out  1  sticky: in_valid arrived while busy.

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE: on in_valid, register in_a, in_b and in_opcode into unit_a, unit_b and unit_op, then go to CHECK.
- CHECK, using the registered values:
  - unmapped opcode → BADOP;
  - DIV with b==0 → DIV0;
  - SQRT with a<0 → DOMAIN;
  - LOG with a≤0 → DOMAIN;
  - any error → DONE with result=0 and no unit started;
  - otherwise → ISSUE.
- ISSUE: assert unit_start[sel] for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: the counter increments each cycle.
  - unit_done[sel] → capture unit_res slice sel; err_code = UNITERR if unit_err[sel], else OK; go to DONE.
  - Done/err bits of non-selected units are ignored.
  - Counter reaches TIMEOUT-1 without done → pulse unit_abort[sel], result=0, err_code=TIMEOUT, go to DONE.
- DONE: res_valid=1 for one cycle, then IDLE.
- in_valid outside IDLE: request dropped, overrun set. overrun clears only on reset.
- abort, highest priority in every state:
  - next state IDLE, no res_valid, result and err_code unchanged;
  - in WAIT, also pulse unit_abort[sel].
- abort coinciding with unit_done or in_valid: abort wins, the done/request is discarded.
- Timeout and unit_done in the same cycle: done wins.
- Reset (RST_N=0 at a clock edge), from any state including mid-WAIT:
  - state IDLE;
  - all outputs 0: busy, res_valid, result, err_code, overrun, unit_start, unit_abort, unit_op, unit_a, unit_b;
  - counter 0;
  - no unit_abort pulse is issued.

## Timing
- in_valid at cycle t (IDLE) → CHECK at t+1, ISSUE at t+2 (unit_start high during t+2), WAIT from t+3.
- Units must not assert done in their start cycle; done sampled from t+3 on.
- unit_done at cycle d → res_valid and new result visible at d+1; IDLE at d+2, the earliest cycle a new request is accepted.
- Pre-check error: res_valid at t+2, IDLE at t+3.
- Timeout: TIMEOUT WAIT cycles; unit_abort pulses on the last WAIT cycle, res_valid the cycle after.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- SUM, a=100, b=-25; ALU returns done 2 cycles after start with res=75 → unit_start=000001 at t+2, res_valid at t+5, result=75, err_code=0.
- DIV, a=50, b=0 → no unit_start, res_valid at t+2, result=0, err_code=2; busy low at t+3.
- LOG a=0 → err_code=3; SQRT a=-4 → err_code=3; opcode outside the define.v set → err_code=1.
- MUL, unit never responds, TIMEOUT=8 → unit_abort=000010 on the 8th WAIT cycle, res_valid next cycle, err_code=4.
- SIN issued, second in_valid during WAIT, then abort coinciding with unit_done[5] → overrun=1, no res_valid, IDLE next cycle, unit_abort=100000.
- RST_N low during WAIT → all outputs 0 next cycle; a following POW request with unit_err[4] on done → err_code=5.
